// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Width needed to hold a counter value in 0..max
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner selection between CPU and DMA
import dmem_arb_pkg::*;

module dmem_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output owner_t           grant_owner
);

    logic starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // DMA wins when CPU is quiet or DMA has waited too long; CPU wins ties otherwise
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWN_CPU;
        if (dma_req && (!cpu_req || starved)) begin
            grant_valid = 1'b1;
            grant_owner = OWN_DMA;
        end else if (cpu_req) begin
            grant_valid = 1'b1;
            grant_owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between the CPU MEM stage and a DMA loader
import dmem_arb_pkg::*;

module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = cnt_width(STARVE_MAX);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t        state;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  starve_cnt;

    logic              grant_valid;
    owner_t            grant_owner;
    logic              busy;
    logic              lat_last;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign busy     = (state == BUSY);
    assign lat_last = (lat_cnt == LAT_W'(MEM_LAT - 1));

    // Memory strobes only while BUSY; the write fires on the last cycle so it commits once
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_read  = busy & ~we_q;
    assign mem_write = busy & we_q & lat_last;
    assign mem_stall = cpu_req & ~cpu_ready;

    // Arbitration FSM: grant in IDLE, count latency in BUSY, pulse completion in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_ready  <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Starvation only accumulates while DMA is actually waiting
                    if (!dma_req) begin
                        starve_cnt <= '0;
                    end else if (grant_owner == OWN_DMA) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                    if (grant_valid) begin
                        owner   <= grant_owner;
                        we_q    <= (grant_owner == OWN_DMA) ? dma_we    : cpu_we;
                        addr_q  <= (grant_owner == OWN_DMA) ? dma_addr  : cpu_addr;
                        wdata_q <= (grant_owner == OWN_DMA) ? dma_wdata : cpu_wdata;
                        lat_cnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_last) begin
                        if (!we_q) begin
                            if (owner == OWN_DMA) begin
                                dma_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        cpu_ready <= (owner == OWN_CPU);
                        dma_done  <= (owner == OWN_DMA);
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    dma_done  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cpu_ready <= 1'b0;
                    dma_done  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
import dmem_arb_pkg::*;

module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0;
    logic [63:0] cpu_rdata;
    logic        cpu_ready, mem_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [63:0] dma_addr = '0, dma_wdata = '0;
    logic [63:0] dma_rdata;
    logic        dma_done;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [63:0] mem [0:255];

    typedef struct {
        bit          is_dma;
        int          cyc;
        bit          chk;
        logic [63:0] data;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cnt, wr_cnt, st_cnt, rdy_cnt, wr_cyc;
    logic [63:0] last_wr_addr, last_wr_data;

    dmem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_stall (mem_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_done  (dma_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge
    assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 64'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; st_cnt = 0; rdy_cnt = 0; wr_cyc = -1;
        last_wr_addr = '0; last_wr_data = '0;
    endtask

    task automatic push(input bit is_dma, input int c, input bit chk, input logic [63:0] d);
        exp_t e;
        e.is_dma = is_dma; e.cyc = c; e.chk = chk; e.data = d;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every completion pulse, tallies strobes
    always @(negedge clk) begin
        if (reset) begin
            if (mem_read)  rd_cnt++;
            if (mem_stall) st_cnt++;
            if (cpu_ready) rdy_cnt++;
            if (mem_write) begin
                wr_cnt++;
                wr_cyc = cyc;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (cpu_ready || dma_done) begin
                if (cpu_ready && dma_done) check("dual_pulse", 64'd1, 64'd0);
                if (q.size() == 0) begin
                    check("unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pulse_owner", {63'd0, dma_done}, {63'd0, e.is_dma});
                    check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.chk) check("rdata", e.is_dma ? dma_rdata : cpu_rdata, e.data);
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h101;
        mem[8'h10] = 64'hAB;
        mem[8'h20] = 64'hCD;
        clear_counts();

        // Reset state
        #7;
        check("rst_cpu_ready", {63'd0, cpu_ready}, 64'd0);
        check("rst_dma_done",  {63'd0, dma_done}, 64'd0);
        check("rst_mem_read",  {63'd0, mem_read}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_addr",  mem_addr, 64'd0);
        check("rst_cpu_rdata", cpu_rdata, 64'd0);
        check("rst_dma_rdata", dma_rdata, 64'd0);
        check("rst_stall",     {63'd0, mem_stall}, 64'd0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // 1: CPU read of 0x10
        t = cyc; clear_counts();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
        push(1'b0, t + 3, 1'b1, 64'hAB);
        tick(3);
        cpu_req = 1'b0;
        tick(2);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd2);
        check("t1_stall_cnt", 64'(st_cnt), 64'd3);
        check("t1_wr_cnt", 64'(wr_cnt), 64'd0);

        // 2: DMA write 0x55 to 0x08
        t = cyc; clear_counts();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h08; dma_wdata = 64'h55;
        push(1'b1, t + 3, 1'b0, 64'h0);
        tick(3);
        dma_req = 1'b0; dma_we = 1'b0;
        tick(2);
        check("t2_wr_cnt", 64'(wr_cnt), 64'd1);
        check("t2_wr_cycle", 64'(wr_cyc), 64'(t + 2));
        check("t2_wr_addr", last_wr_addr, 64'h08);
        check("t2_wr_data", last_wr_data, 64'h55);
        check("t2_rd_cnt", 64'(rd_cnt), 64'd0);

        // 3: both held continuously -> CPU x4, DMA, CPU
        t = cyc; clear_counts();
        cpu_req = 1'b1; cpu_addr = 64'h10;
        dma_req = 1'b1; dma_addr = 64'h20;
        for (int k = 0; k < 4; k++) push(1'b0, t + 3 + 4 * k, 1'b1, 64'hAB);
        push(1'b1, t + 19, 1'b1, 64'hCD);
        push(1'b0, t + 23, 1'b1, 64'hAB);
        tick(16);
        check("t3_starve_full", 64'(dut.starve_cnt), 64'd4);
        tick(1);
        check("t3_starve_clear", 64'(dut.starve_cnt), 64'd0);
        tick(6);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick(2);

        // 4: simultaneous first requests -> CPU first, DMA done at t+7
        t = cyc;
        cpu_req = 1'b1; cpu_addr = 64'h20;
        dma_req = 1'b1; dma_addr = 64'h10;
        push(1'b0, t + 3, 1'b1, 64'hCD);
        push(1'b1, t + 7, 1'b1, 64'hAB);
        tick(3);
        cpu_req = 1'b0;
        tick(4);
        dma_req = 1'b0;
        tick(2);

        // 5: reset during first BUSY cycle of a CPU write
        t = cyc; clear_counts();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h18; cpu_wdata = 64'h77;
        tick(1);
        reset = 1'b0;
        #1;
        check("t5_state", 64'(dut.state), 64'(IDLE));
        check("t5_mem_read", {63'd0, mem_read}, 64'd0);
        check("t5_mem_write", {63'd0, mem_write}, 64'd0);
        check("t5_mem_addr", mem_addr, 64'd0);
        check("t5_mem_wdata", mem_wdata, 64'd0);
        check("t5_cpu_rdata", cpu_rdata, 64'd0);
        check("t5_dma_rdata", dma_rdata, 64'd0);
        check("t5_stall_follows", {63'd0, mem_stall}, 64'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("t5_stall_drop", {63'd0, mem_stall}, 64'd0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("t5_wr_cnt", 64'(wr_cnt), 64'd0);
        check("t5_mem_kept", mem[8'h18], 64'h18 * 64'h101);

        // 6: CPU drops request right after grant
        t = cyc; clear_counts();
        cpu_req = 1'b1; cpu_addr = 64'h20;
        push(1'b0, t + 3, 1'b1, 64'hCD);
        tick(1);
        cpu_req = 1'b0;
        tick(8);
        check("t6_rd_cnt", 64'(rd_cnt), 64'd2);
        check("t6_rdy_cnt", 64'(rdy_cnt), 64'd1);

        check("scoreboard_left", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU) and a DMA/loader requester that preloads and reads back the array elements.
- Sequences each access over a fixed multi-cycle memory latency.
- Drives a stall to the pipeline while a CPU access is pending.
- Sits between the EX/MEM register outputs and data memory; the DMA side connects to the testbench/loader.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LAT, 2, memory busy cycles per access; must be >= 1.
- STARVE_MAX, 4, consecutive CPU grants with DMA waiting before DMA is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- cpu_req  in  1  CPU access request, held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_stall  out  1  pipeline stall = cpu_req & ~cpu_ready (combinational).
- dma_req  in  1  DMA request, held until dma_done.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data, valid while dma_done.
- dma_done  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, reset=0):
  - state=IDLE, owner=CPU, lat_cnt=0, starve_cnt=0.
  - All outputs 0, except mem_stall, which follows cpu_req.
- IDLE arbitration, evaluated each cycle:
  - DMA wins if dma_req & (~cpu_req | starve_cnt==STARVE_MAX).
  - Otherwise CPU wins if cpu_req.
  - Otherwise stay in IDLE.
- Grant: on the clock edge, latch owner, we, addr, wdata into internal registers; go to BUSY with lat_cnt=0.
- BUSY:
  - mem_addr/mem_wdata come from the latched registers.
  - mem_read = ~we for all MEM_LAT cycles.
  - mem_write = we, only in the final BUSY cycle (lat_cnt==MEM_LAT-1), so writes commit exactly once.
  - On the final cycle, capture mem_rdata into the read-data register (reads only) and go to DONE.
- DONE (1 cycle):
  - Pulse cpu_ready or dma_done per owner; the matching rdata output holds the captured data.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle t gives a completion pulse at t+MEM_LAT+1. Minimum back-to-back period is MEM_LAT+2 cycles.
- rdata outputs hold their last value until the next completion for that requester; they are 0 after reset.
- In IDLE and DONE, mem_addr, mem_wdata, mem_read and mem_write are 0.
- Starvation counter:
  - CPU grant with dma_req=1: increment, saturating at STARVE_MAX.
  - DMA grant: clear.
  - dma_req=0 in IDLE: clear.
- Request dropped mid-transaction: ignored. The access completes and the pulse still fires. The requester must not change addr/data after the grant, and the block does not sample them after the grant.
- Simultaneous cpu_req & dma_req with starve_cnt<STARVE_MAX: CPU wins.
- Reset asserted mid-BUSY:
  - Immediate return to IDLE; no completion pulse.
  - A write is not committed unless its final BUSY cycle had already been clocked.
- A req that rises in the DONE cycle is arbitrated in the following IDLE cycle.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - owner encoding {OWN_CPU=0, OWN_DMA=1}.
- One sub-module, dmem_arb_pick: combinational winner selection from cpu_req, dma_req, starve_cnt, STARVE_MAX.
- The top module holds the FSM, latency counter, latch registers and starvation counter.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
1. Reset, then CPU read addr 0x10 with mem returning 0xAB → mem_read high 2 cycles; cpu_ready pulse 3 cycles after req; cpu_rdata=0xAB; mem_stall high for 3 cycles.
2. DMA write addr 0x08 data 0x55 → mem_write high exactly 1 cycle (2nd BUSY cycle) with mem_addr=0x08, mem_wdata=0x55; dma_done 3 cycles after req.
3. cpu_req and dma_req held continuously → grant order CPU,CPU,CPU,CPU,DMA,CPU...; starve_cnt reaches 4 and then clears.
4. Simultaneous first requests from CPU and DMA → CPU served first; DMA done pulse at cycle 7 (3+1 IDLE+3).
5. Reset asserted during the 1st BUSY cycle of a CPU write → no mem_write, no cpu_ready; state IDLE; all outputs 0.
6. cpu_req dropped after grant → cpu_ready still pulses once; no second access is started.
